// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among NREQ
// writeback sources; registers the winner and drives a one-hot write-enable.
module regfile_write_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 32,
  parameter int ZERO_RO = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              Stall,
  input  logic [NREQ-1:0]   Req,
  input  logic [NREQ*5-1:0] Addr,
  input  logic [NREQ*DW-1:0] Data,
  output logic [NREQ-1:0]   Gnt,
  output logic [31:0]       WrEn,
  output logic [4:0]        WrAddr,
  output logic [DW-1:0]     WrData,
  output logic              WrValid
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] ptr_next;
  logic [PW:0]   sum;
  logic          found;
  logic          grant;
  logic [4:0]    sel_addr;
  logic [DW-1:0] sel_data;
  logic [31:0]   wr_en_next;
  logic [4:0]    addr_a [NREQ];
  logic [DW-1:0] data_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i] = Addr[i*5 +: 5];
    assign data_a[i] = Data[i*DW +: DW];
  end

  // Scan from farthest to nearest so the requester closest to ptr wins last.
  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(NREQ)) sum = sum - (PW+1)'(NREQ);
      if (Req[sum[PW-1:0]]) begin
        found   = 1'b1;
        gnt_idx = sum[PW-1:0];
      end
    end
  end

  assign grant    = found & ~Stall & Rst_n;
  assign Gnt      = grant ? (NREQ'(1) << gnt_idx) : '0;
  assign sel_addr = addr_a[gnt_idx];
  assign sel_data = data_a[gnt_idx];
  assign ptr_next = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  // Register 0 is hardwired when ZERO_RO is set: the write is accepted but suppressed.
  assign wr_en_next = ((ZERO_RO != 0) && (sel_addr == 5'd0)) ? '0 : (32'(1) << sel_addr);

  // ---- grant edge -> registered write port ----
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ptr     <= '0;
      WrValid <= 1'b0;
      WrEn    <= '0;
      WrAddr  <= '0;
      WrData  <= '0;
    end else if (grant) begin
      ptr     <= ptr_next;
      WrValid <= 1'b1;
      WrEn    <= wr_en_next;
      WrAddr  <= sel_addr;
      WrData  <= sel_data;
    end else begin
      WrValid <= 1'b0;
      WrEn    <= '0;
    end
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomized checks of regfile_write_arbiter against a queue-free
// round-robin reference model kept in plain integers.
module tb_regfile_write_arbiter;

  localparam int NREQ = 4;
  localparam int DW   = 32;

  logic           Clk;
  logic           Rst_n;
  logic           Stall;
  logic [3:0]     Req;
  logic [19:0]    Addr;
  logic [127:0]   Data;
  logic [3:0]     Gnt;
  logic [31:0]    WrEn;
  logic [4:0]     WrAddr;
  logic [31:0]    WrData;
  logic           WrValid;

  regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .ZERO_RO(1)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Stall(Stall), .Req(Req), .Addr(Addr), .Data(Data),
    .Gnt(Gnt), .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .WrValid(WrValid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int vectors = 0;
  int errors  = 0;

  // reference model state
  int          m_ptr;
  logic        m_valid;
  logic [31:0] m_en;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [3:0]  gnt_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int model_grant(input logic stall, input logic [3:0] req);
    if (stall) return -1;
    for (int i = 0; i < NREQ; i++)
      if (req[(m_ptr + i) % NREQ]) return (m_ptr + i) % NREQ;
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_valid = 1'b0; m_en = '0; m_addr = '0; m_data = '0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_wrvalid"}, 64'(WrValid), 64'(m_valid));
    chk({tag, "_wren"},    64'(WrEn),    64'(m_en));
    chk({tag, "_wraddr"},  64'(WrAddr),  64'(m_addr));
    chk({tag, "_wrdata"},  64'(WrData),  64'(m_data));
  endtask

  // Called 1 time unit after a rising edge; leaves time 1 unit after the next edge.
  task automatic cycle(input string tag, input logic stall, input logic [3:0] req,
                       input logic [19:0] addr, input logic [127:0] data);
    int g;
    Stall = stall; Req = req; Addr = addr; Data = data;
    #2;
    g = model_grant(stall, req);
    gnt_seen = Gnt;
    chk({tag, "_gnt"}, 64'(Gnt), (g < 0) ? 64'd0 : (64'd1 << g));
    @(posedge Clk); #1;
    if (g >= 0) begin
      m_ptr   = (g + 1) % NREQ;
      m_valid = 1'b1;
      m_addr  = addr[g*5 +: 5];
      m_data  = data[g*32 +: 32];
      m_en    = (m_addr == 5'd0) ? 32'd0 : (32'd1 << m_addr);
    end else begin
      m_valid = 1'b0;
      m_en    = '0;
    end
    check_outputs(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0]  a;
    logic [127:0] d;
    model_reset();
    Rst_n = 1'b0; Stall = 1'b0; Req = 4'b1111; Addr = '0; Data = '0;
    #12;
    chk("rst_gnt", 64'(Gnt), 64'd0);
    check_outputs("rst");
    Rst_n = 1'b1;

    // first cycle after reset release grants requester 0
    a = {5'd4, 5'd3, 5'd2, 5'd1};
    d = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    cycle("rel", 1'b0, 4'b1111, a, d);
    chk("rel_first_gnt", 64'(gnt_seen), 64'h1);

    // single write
    model_reset(); Rst_n = 1'b0; #1; Rst_n = 1'b1;
    a = {5'd0, 5'd17, 5'd0, 5'd0};
    d = {32'h0, 32'hDEADBEEF, 64'h0};
    cycle("single", 1'b0, 4'b0100, a, d);
    chk("single_gnt_c", 64'(gnt_seen), 64'h4);
    chk("single_wren_c", 64'(WrEn), 64'h0002_0000);
    chk("single_wrdata_c", 64'(WrData), 64'hDEADBEEF);

    // round-robin, 8 cycles with all requesting
    a = {5'd31, 5'd9, 5'd5, 5'd1};
    d = {32'hA0A0_0003, 32'hA0A0_0002, 32'hA0A0_0001, 32'hA0A0_0000};
    for (int i = 0; i < 8; i++) cycle("rr", 1'b0, 4'b1111, a, d);

    // write to register 0 is accepted but produces no enable
    a = {5'd7, 5'd7, 5'd0, 5'd7};
    d = {32'h0, 32'h0, 32'hCAFE_0000, 32'h0};
    cycle("r0", 1'b0, 4'b0010, a, d);
    chk("r0_valid_c", 64'(WrValid), 64'h1);
    chk("r0_wren_c", 64'(WrEn), 64'h0);

    // stall mid-burst, then resume at the pointed requester
    a = {5'd0, 5'd0, 5'd12, 5'd11};
    d = {64'h0, 32'hB1, 32'hB0};
    cycle("stl0", 1'b0, 4'b0011, a, d);
    cycle("stl1", 1'b1, 4'b0011, a, d);
    cycle("stl2", 1'b1, 4'b0011, a, d);
    cycle("stl3", 1'b0, 4'b0011, a, d);
    cycle("stl4", 1'b0, 4'b0011, a, d);

    // asynchronous reset between edges with a write registered
    a = {5'd20, 5'd21, 5'd22, 5'd23};
    d = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    cycle("pre_arst", 1'b0, 4'b1111, a, d);
    chk("pre_arst_valid_c", 64'(WrValid), 64'h1);
    #2;
    Rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst_gnt", 64'(Gnt), 64'd0);
    check_outputs("arst");
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    cycle("post_arst", 1'b0, 4'b1111, a, d);
    chk("post_arst_gnt_c", 64'(gnt_seen), 64'h1);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      a = 20'($urandom);
      d = {$urandom, $urandom, $urandom, $urandom};
      cycle("rand", ($urandom_range(0, 4) == 0), 4'($urandom), a, d);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port among NREQ requesters, e.g. ALU writeback, load writeback and the debug port.
- Chooses one requester per cycle using round-robin order.
- Registers the winner's address and data, then drives the register file with a one-hot 32-bit write-enable decoded from the 5-bit address.
- Sits between the writeback sources and the register file, in place of a bare 5-to-32 write decoder.

Parameters:
- NREQ, 4, number of requesters; legal range 2..8.
- DW, 32, write data width in bits.
- ZERO_RO, 1, when 1 a write to register 0 is granted but produces no write-enable.

Ports:
- Clk  input  1  rising-edge clock.
- Rst_n  input  1  asynchronous active-low reset.
- Stall  input  1  pipeline stall; while high no grants are issued and no writes occur.
- Req  input  NREQ  per-requester write request, level-sensitive.
- Addr  input  NREQ*5  requester i's target register, in bits [5i+4:5i].
- Data  input  NREQ*DW  requester i's write data, in bits [DW*i+DW-1:DW*i].
- Gnt  output  NREQ  combinational one-hot grant; a request is consumed at the clock edge where Gnt[i]=1.
- WrEn  output  32  registered one-hot register-file write-enable.
- WrAddr  output  5  registered address of the current write.
- WrData  output  DW  registered data of the current write.
- WrValid  output  1  registered; high for one cycle per accepted request, including accepted writes to register 0.

Behaviour:
- Reset: Rst_n=0 asynchronously clears WrEn, WrAddr, WrData, WrValid and the round-robin pointer Ptr. Gnt is forced to 0 while Rst_n=0.
- Reset mid-operation: any request not yet consumed is discarded. Requesters re-present requests after reset is released. No partial write ever appears.
- Ptr: log2(NREQ)-bit register naming the highest-priority requester for the current cycle.
- Arbitration (combinational):
  - If Stall=0 and Req is non-zero, Gnt selects the first i with Req[i]=1, scanning Ptr, Ptr+1, … modulo NREQ.
  - Otherwise Gnt=0.
  - Gnt is always zero or one-hot.
- Handshake:
  - A requester holds Req, Addr and Data stable until it sees Gnt[i]=1 at a clock edge.
  - It may deassert Req the following cycle or keep it high for another write.
  - Deasserting Req before a grant withdraws the request; this is legal.
- State update at each rising Clk edge:
  - If grant g is issued: Ptr <= (g+1) mod NREQ; WrValid <= 1; WrAddr <= Addr[g]; WrData <= Data[g].
  - WrEn <= one-hot(Addr[g]). Exception: WrEn <= 0 when Addr[g]=0 and ZERO_RO=1.
  - If no grant is issued: WrValid <= 0, WrEn <= 0, WrAddr and WrData hold, Ptr holds.
- Latency: the write appears on WrEn/WrData exactly 1 cycle after the grant edge. Back-to-back grants give one write per cycle with no bubble.
- Fairness: a requester that holds Req continuously with Stall=0 is granted within NREQ cycles.
- Single requester: it is granted every cycle it requests.
- Stall:
  - Stall=1 blocks grants combinationally in the same cycle.
  - Outputs go idle (WrEn=0, WrValid=0) at the next edge; Ptr holds.
  - A write already registered before Stall rose completes normally.
- Simultaneous requests: exactly one grant per cycle; the others wait, with Gnt low.
- Pointer wrap: Ptr at NREQ-1 plus a grant to NREQ-1 wraps to 0.
- WrEn invariant: WrEn is zero or one-hot. When WrValid=0, WrEn=0. Bit k of WrEn is set only when WrAddr=k.

Test Plan:
- Reset: hold Rst_n=0 with Req=4'b1111 -> Gnt=0, WrEn=0, WrValid=0, Ptr=0. Release reset -> Gnt=4'b0001 on the first cycle.
- Single write: Req=4'b0100, Addr[2]=5'd17, Data[2]=32'hDEADBEEF -> Gnt=4'b0100 that cycle; next cycle WrEn=32'h0002_0000, WrAddr=17, WrData=32'hDEADBEEF, WrValid=1.
- Round-robin: Req=4'b1111 held for 8 cycles -> Gnt sequence 0001, 0010, 0100, 1000, 0001, …; each WrEn matches the granted Addr one cycle later.
- Register 0 with ZERO_RO=1: Req[1] with Addr=0 -> Gnt[1]=1; next cycle WrValid=1, WrAddr=0, WrEn=0.
- Stall mid-burst: Req=4'b0011, Stall=1 on cycle 2 for 2 cycles -> Gnt=0 during the stall; WrEn=0 one cycle later; Ptr unchanged; grants resume at the pointed requester when Stall falls.
- Asynchronous reset mid-burst: drop Rst_n between edges -> outputs clear immediately with no clock edge; after release the pointer restarts at requester 0.
